sync_fifo_flags: RTL and testbench

Parametrised single-clock FIFO and successor to the basic synchronous FIFO. Adds:
- configurable depth and width
- occupancy output
- programmable almost-full and almost-empty thresholds
- overflow and underflow error pulses
- registered read data with a valid strobe

It sits between producer and consumer pipelines in the same clock domain.

---
 rtl/sync_fifo_pkg.sv | 26 ++
 rtl/fifo_ram.sv | 69 ++++++
 rtl/sync_fifo_flags.sv | 166 ++++++++++++++++
 tb/tb_sync_fifo_flags.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared constants, helpers and types for sync_fifo_flags
//
// Purpose: default geometry of the FIFO, a constant-foldable ceil(log2)
// helper used to size pointers, and the occupancy type for the default depth.
// Optional feature macro used by this slice: SYNC_FIFO_FWFT_EN.

package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_FIFO_DEPTH = 16;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Occupancy needs one bit more than a pointer so that "full" (== depth)
  // is representable alongside 0..depth-1.
  typedef logic [clog2(DEFAULT_FIFO_DEPTH):0] level_t;

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - simple dual-port storage array for sync_fifo_flags
//
// Purpose: one write port, one read port. The read port offers both a
// registered output (updated only when rd_en_i is high, reset to zero) and
// an asynchronous output of the addressed word for first-word-fall-through.
// The array itself is never reset.
//
// Ports:
//   clk              clock, rising edge
//   rst_n            synchronous active-low reset (registered read data only)
//   wr_en_i          write strobe
//   wr_addr_i        write address
//   wr_data_i        write word
//   rd_en_i          load the registered read output
//   rd_addr_i        read address
//   rd_data_o        registered read word
//   rd_data_async_o  combinational read word at rd_addr_i

module fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int ADDR_WIDTH = clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [DATA_WIDTH-1:0] rd_data_async_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  // Storage is deliberately left out of reset: stale contents are never
  // observable because the pointers and level are reset instead.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_async_o = mem_q[rd_addr_i];

  // Read register holds its value between pops.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      rd_data_d = mem_q[rd_addr_i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with occupancy, thresholds and error pulses
//
// Purpose: parametrised synchronous FIFO between producer and consumer
// pipelines in one clock domain. Tracks occupancy in a single counter,
// derives full/empty/almost flags from it, and pulses overflow/underflow
// for each rejected request.
//
// Optional feature macro: SYNC_FIFO_FWFT_EN
//   undefined : rd_data is registered, rd_valid pulses one cycle after an
//               accepted read (1-cycle latency).
//   defined   : first-word-fall-through; rd_data shows the head word whenever
//               the FIFO is not empty, rd_valid = !empty, rd_en pops.
//
// Ports:
//   clk           clock, rising edge
//   rst_n         synchronous active-low reset
//   wr_en         write request
//   wr_data       write word
//   rd_en         read request (pop in FWFT mode)
//   rd_data       read word
//   rd_valid      rd_data holds a newly popped word (head valid in FWFT)
//   full          level == FIFO_DEPTH
//   empty         level == 0
//   almost_full   level >= AF_THRESH
//   almost_empty  level <= AE_THRESH
//   level         current occupancy, 0..FIFO_DEPTH
//   overflow      one-cycle pulse: write rejected
//   underflow     one-cycle pulse: read rejected

module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter  int AF_THRESH  = FIFO_DEPTH - 2,
  parameter  int AE_THRESH  = 2,
  localparam int ADDR_WIDTH = clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_LVL = (ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_LVL    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q,  level_d;
  logic                  overflow_q,  overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ram_rd_en;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic [DATA_WIDTH-1:0] ram_rd_data_async;

  // Flags are pure compares of the registered level, so they reflect an
  // operation the cycle after it is accepted.
  assign full         = (level_q == DEPTH_LVL);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= AF_LVL);
  assign almost_empty = (level_q <= AE_LVL);
  assign level        = level_q;

  // Acceptance uses the pre-edge flags: a full FIFO drops a write even when a
  // read frees a slot in the same cycle, and an empty FIFO never bypasses.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = wr_en & full;
    underflow_d = rd_en & empty;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_ram (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_en_i         (wr_acc),
    .wr_addr_i       (wr_ptr_q),
    .wr_data_i       (wr_data),
    .rd_en_i         (ram_rd_en),
    .rd_addr_i       (rd_ptr_q),
    .rd_data_o       (ram_rd_data),
    .rd_data_async_o (ram_rd_data_async)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is shown combinationally; the registered read port is idle.
  logic [DATA_WIDTH-1:0] unused_ram_rd_data;

  assign ram_rd_en          = 1'b0;
  assign unused_ram_rd_data = ram_rd_data;
  assign rd_data            = ram_rd_data_async;
  assign rd_valid           = ~empty;
`else
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] unused_ram_rd_data_async;

  assign ram_rd_en                = rd_acc;
  assign unused_ram_rd_data_async = ram_rd_data_async;
  assign rd_data                  = ram_rd_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
    end
  end

  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - self-checking bench for sync_fifo_flags against a queue model

module tb_sync_fifo_flags;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [4:0]    level;
  logic          overflow;
  logic          underflow;

  int total;
  int bad;

  // Reference model: contents as a plain queue plus expected pulse outputs.
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_rd;
  bit            exp_val;
  bit            exp_ovf;
  bit            exp_udf;

  sync_fifo_flags dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = q.size();
    chk({tag, "/level"},        32'(level),        32'(n));
    chk({tag, "/empty"},        32'(empty),        32'(n == 0));
    chk({tag, "/full"},         32'(full),         32'(n == DEPTH));
    chk({tag, "/almost_full"},  32'(almost_full),  32'(n >= AF));
    chk({tag, "/almost_empty"}, 32'(almost_empty), 32'(n <= AE));
    chk({tag, "/overflow"},     32'(overflow),     32'(exp_ovf));
    chk({tag, "/underflow"},    32'(underflow),    32'(exp_udf));
`ifdef SYNC_FIFO_FWFT_EN
    chk({tag, "/rd_valid"},     32'(rd_valid),     32'(n != 0));
    if (n != 0) begin
      chk({tag, "/rd_data"},    32'(rd_data),      32'(q[0]));
    end
`else
    chk({tag, "/rd_valid"},     32'(rd_valid),     32'(exp_val));
    chk({tag, "/rd_data"},      32'(rd_data),      32'(exp_rd));
`endif
  endtask

  // One clock of stimulus; the model applies the acceptance rules on the
  // pre-edge occupancy, then outputs are compared 1 time unit after the edge.
  task automatic step(input string tag, input bit w, input logic [DW-1:0] d, input bit r);
    int n;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    n       = q.size();
    exp_ovf = w && (n == DEPTH);
    exp_udf = r && (n == 0);
    exp_val = 1'b0;
    if (r && n > 0) begin
      exp_rd  = q.pop_front();
      exp_val = 1'b1;
    end
    if (w && n < DEPTH) begin
      q.push_back(d);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    exp_rd  = '0;
    exp_val = 1'b0;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    check_outputs(tag);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    exp_rd  = '0;

    // Reset, then idle.
    @(posedge clk);
    #1;
    do_reset("reset");
    for (int i = 0; i < 5; i++) step("idle", 1'b0, 8'h00, 1'b0);

    // Fill with 0x00..0x0F, watching the almost_full edge.
    for (int i = 0; i < DEPTH; i++) begin
      step("fill", 1'b1, 8'(i), 1'b0);
      if (i == 12) chk("af_low_at_13", 32'(almost_full), 32'd0);
      if (i == 13) chk("af_high_at_14", 32'(almost_full), 32'd1);
    end
    chk("full_at_16", 32'(full), 32'd1);
    chk("level_at_16", 32'(level), 32'd16);
    step("overflow", 1'b1, 8'hAA, 1'b0);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    step("ovf_clear", 1'b0, 8'h00, 1'b0);
    chk("ovf_one_cycle", 32'(overflow), 32'd0);
    chk("level_after_ovf", 32'(level), 32'd16);

    // Drain in order.
    for (int i = 0; i < DEPTH; i++) begin
`ifndef SYNC_FIFO_FWFT_EN
      step("drain", 1'b0, 8'h00, 1'b1);
      chk("drain_order", 32'(rd_data), 32'(i));
`else
      chk("drain_order", 32'(rd_data), 32'(i));
      step("drain", 1'b0, 8'h00, 1'b1);
`endif
    end
    chk("empty_after_drain", 32'(empty), 32'd1);
    step("underflow", 1'b0, 8'h00, 1'b1);
    chk("udf_pulse", 32'(underflow), 32'd1);
    step("udf_clear", 1'b0, 8'h00, 1'b0);
    chk("udf_one_cycle", 32'(underflow), 32'd0);

    // Steady state at level 5 with simultaneous traffic across pointer wrap.
    for (int i = 0; i < 5; i++) step("pre5", 1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) step("simul5", 1'b1, 8'($urandom), 1'b1);
    chk("level_stays_5", 32'(level), 32'd5);

    // Full plus simultaneous read/write: read served, write dropped.
    while (q.size() < DEPTH) step("refill", 1'b1, 8'($urandom), 1'b0);
    step("full_simul", 1'b1, 8'hBB, 1'b1);
    chk("full_simul_level", 32'(level), 32'd15);
    chk("full_simul_ovf", 32'(overflow), 32'd1);

    // Reset at level 9 discards contents.
    while (q.size() > 9) step("to9", 1'b0, 8'h00, 1'b1);
    chk("level_is_9", 32'(level), 32'd9);
    do_reset("mid_reset");
    chk("mid_reset_level", 32'(level), 32'd0);
    chk("mid_reset_empty", 32'(empty), 32'd1);
    step("post_reset_read", 1'b0, 8'h00, 1'b1);
    chk("post_reset_udf", 32'(underflow), 32'd1);
    chk("post_reset_no_valid", 32'(rd_valid), 32'd0);

    // Single write into an empty FIFO.
    step("write_3c", 1'b1, 8'h3C, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_valid", 32'(rd_valid), 32'd1);
    chk("fwft_data", 32'(rd_data), 32'h3C);
`else
    chk("reg_no_valid", 32'(rd_valid), 32'd0);
`endif

    // Random traffic, with phases biased toward filling and draining.
    for (int i = 0; i < 600; i++) begin
      bit w;
      bit r;
      if (i < 200) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else if (i < 400) begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end else begin
        w = $urandom_range(0, 1) == 1;
        r = $urandom_range(0, 1) == 1;
      end
      step("random", w, 8'($urandom), r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
